multiple_gain_pipe: RTL and testbench

//  Pipelined N-channel gain stage. Each lane computes data*gain at full precision,

---
 rtl/multiple_gain_pipe.sv | 116 +++++++++++
 tb/tb_multiple_gain_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiple_gain_pipe.sv
// Pipelined N-lane gain stage: product, round-half-up shift, saturate, valid/ready stream.
// Define MULTIPLE_GAIN_PIPE_SAT_FLAG_EN to add the per-lane o_sat clamp flag output.
module multiple_gain_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INOUT  = 8,
    parameter bit IS_SIGNED  = 1'b1,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int EXTRA_PIPE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data [NUM_INOUT],
    input  logic [DATA_WIDTH-1:0] i_gain [NUM_INOUT],
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_data [NUM_INOUT]
`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
    ,
    output logic [NUM_INOUT-1:0]  o_sat
`endif
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int RW = PW + 2;
    localparam int ND = EXTRA_PIPE + 1;
    localparam logic [RW-1:0] RND = (RW'(1) << SHIFT) >> 1;

    generate
        if ((OUT_WIDTH + SHIFT > PW) || (EXTRA_PIPE < 0) || (EXTRA_PIPE > 4)) begin : g_param_chk
            $error("multiple_gain_pipe: illegal OUT_WIDTH/SHIFT/EXTRA_PIPE combination");
        end
    endgenerate

    logic                  advance;
    logic                  v0;
    logic [DATA_WIDTH-1:0] d0 [NUM_INOUT];
    logic [DATA_WIDTH-1:0] g0 [NUM_INOUT];
    logic [ND-1:0]         vp;
    logic [PW-1:0]         prod [ND][NUM_INOUT];
    logic [PW-1:0]         prod_c [NUM_INOUT];
    logic [OUT_WIDTH-1:0]  res [NUM_INOUT];
    logic [NUM_INOUT-1:0]  sat_c;

    assign advance = ~o_valid | i_ready;
    assign o_ready = advance;

    for (genvar l = 0; l < NUM_INOUT; l++) begin : g_lane
        logic          ext_d;
        logic          ext_g;
        logic          ext_p;
        logic [PW-1:0] de;
        logic [PW-1:0] ge;
        logic [RW-1:0] sum;
        logic [RW-1:0] r;

        // The low PW bits of a PW x PW product are exact for both signednesses.
        assign ext_d      = IS_SIGNED & d0[l][DATA_WIDTH-1];
        assign ext_g      = IS_SIGNED & g0[l][DATA_WIDTH-1];
        assign de         = {{DATA_WIDTH{ext_d}}, d0[l]};
        assign ge         = {{DATA_WIDTH{ext_g}}, g0[l]};
        assign prod_c[l]  = de * ge;

        assign ext_p = IS_SIGNED & prod[ND-1][l][PW-1];
        assign sum   = {{2{ext_p}}, prod[ND-1][l]} + RND;
        assign r     = $signed(sum) >>> SHIFT;

        if (IS_SIGNED) begin : g_signed
            logic [RW-OUT_WIDTH:0] top;
            assign top      = r[RW-1:OUT_WIDTH-1];
            assign sat_c[l] = ~((&top) | ~(|top));
            assign res[l]   = !sat_c[l] ? r[OUT_WIDTH-1:0] :
                              r[RW-1]   ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                          {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin : g_unsigned
            assign sat_c[l] = |r[RW-1:OUT_WIDTH];
            assign res[l]   = sat_c[l] ? {OUT_WIDTH{1'b1}} : r[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v0      <= 1'b0;
            vp      <= '0;
            o_valid <= 1'b0;
            for (int l = 0; l < NUM_INOUT; l++) begin
                o_data[l] <= '0;
            end
`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
            o_sat   <= '0;
`endif
        end else if (advance) begin
            v0      <= i_valid;
            vp[0]   <= v0;
            o_valid <= vp[ND-1];
            for (int l = 0; l < NUM_INOUT; l++) begin
                d0[l]      <= i_data[l];
                g0[l]      <= i_gain[l];
                prod[0][l] <= prod_c[l];
                o_data[l]  <= res[l];
            end
            for (int k = 1; k < ND; k++) begin
                vp[k] <= vp[k-1];
                for (int l = 0; l < NUM_INOUT; l++) begin
                    prod[k][l] <= prod[k-1][l];
                end
            end
`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
            o_sat   <= sat_c;
`endif
        end
    end

endmodule

// File: tb/tb_multiple_gain_pipe.sv
// Scoreboard bench for multiple_gain_pipe: directed Q15 vectors, backpressure, reset, unsigned config.
module tb_multiple_gain_pipe;

    typedef struct packed {
        logic [3:0][15:0] d;
        logic [3:0]       s;
        int               acc;
        bit               lat;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] i_data [4];
    logic [15:0] i_gain [4];
    logic [15:0] o_data [4];

    logic        u_valid = 1'b0;
    logic        u_ready_o;
    logic        u_ovalid;
    logic [15:0] u_data [4];
    logic [15:0] u_gain [4];
    logic [31:0] u_odata [4];

`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
    logic [3:0]  o_sat;
    logic [3:0]  u_osat;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          bp_on = 1'b0;
    logic [31:0] bp_pat = 32'hB4C3_6A59;
    exp_t        q[$];
    exp_t        exp_cur;
    exp_t        e;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data [4];

    multiple_gain_pipe #(
        .DATA_WIDTH(16), .NUM_INOUT(4), .IS_SIGNED(1'b1),
        .OUT_WIDTH(16), .SHIFT(15), .EXTRA_PIPE(0)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_gain(i_gain), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data)
`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
        , .o_sat(o_sat)
`endif
    );

    multiple_gain_pipe #(
        .DATA_WIDTH(16), .NUM_INOUT(4), .IS_SIGNED(1'b0),
        .OUT_WIDTH(32), .SHIFT(0), .EXTRA_PIPE(2)
    ) dut_u (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(u_valid), .o_ready(u_ready_o),
        .i_data(u_data), .i_gain(u_gain), .o_valid(u_ovalid), .i_ready(1'b1),
        .o_data(u_odata)
`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
        , .o_sat(u_osat)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        #1;
        if (bp_on) begin
            i_ready = bp_pat[0];
            bp_pat  = {bp_pat[0], bp_pat[31:1]};
        end else begin
            i_ready = 1'b1;
        end
    end

    // Monitor: pops expected beats on each output handshake; also records accepted inputs.
    always @(negedge i_clk) begin
        if (i_rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (o_ready !== (!o_valid || i_ready)) begin
                errors++;
                $display("FAIL ready_mirror: got %b expected %b", o_ready, (!o_valid || i_ready));
            end
            if (prev_stall) begin
                for (int l = 0; l < 4; l++) begin
                    checks++;
                    if (o_valid !== 1'b1 || o_data[l] !== prev_data[l]) begin
                        errors++;
                        $display("FAIL hold lane %0d: got v=%b %h expected v=1 %h", l, o_valid, o_data[l], prev_data[l]);
                    end
                end
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h %h %h %h expected none", o_data[0], o_data[1], o_data[2], o_data[3]);
                end else begin
                    e = q.pop_front();
                    for (int l = 0; l < 4; l++) begin
                        checks++;
                        if (o_data[l] !== e.d[l]) begin
                            errors++;
                            $display("FAIL data lane %0d: got %h expected %h", l, o_data[l], e.d[l]);
                        end
                    end
`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
                    checks++;
                    if (o_sat !== e.s) begin
                        errors++;
                        $display("FAIL sat: got %b expected %b", o_sat, e.s);
                    end
`endif
                    if (e.lat) begin
                        checks++;
                        if (cyc - e.acc + 1 != 3) begin
                            errors++;
                            $display("FAIL latency: got %0d expected 3", cyc - e.acc + 1);
                        end
                    end
                end
            end
            prev_stall = o_valid && !i_ready;
            for (int l = 0; l < 4; l++) prev_data[l] = o_data[l];
            if (i_valid && o_ready) begin
                exp_cur.acc = cyc + 1;
                q.push_back(exp_cur);
            end
        end
    end

    task automatic send(input logic [3:0][15:0] d, input logic [3:0][15:0] g,
                        input logic [3:0][15:0] ex, input logic [3:0] s, input bit lat);
        int n;
        for (int l = 0; l < 4; l++) begin
            i_data[l] = d[l];
            i_gain[l] = g[l];
        end
        exp_cur.d   = ex;
        exp_cur.s   = s;
        exp_cur.lat = lat;
        i_valid     = 1'b1;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 100) begin
            n++;
            @(negedge i_clk);
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1");
        end
        @(posedge i_clk);
        #1;
    endtask

    // Stream beat k: data is even and gain is 0.5, so each result is exactly data/2.
    task automatic send_stream(input int k, input bit lat);
        logic [3:0][15:0] d, g, ex;
        for (int l = 0; l < 3; l++) begin
            d[l]  = 16'(16'h0100 * (k + 1) + 2 * l);
            ex[l] = 16'(16'h0080 * (k + 1) + l);
            g[l]  = 16'h4000;
        end
        d[3]  = 16'(-(16'h0100 * (k + 1)));
        ex[3] = 16'(-(16'h0080 * (k + 1)));
        g[3]  = 16'h4000;
        send(d, g, ex, 4'b0000, lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            n++;
            @(negedge i_clk);
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d beats outstanding expected 0", q.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data[0] !== 16'h0000) begin
            errors++;
            $display("FAIL %s: got v=%b r=%b d0=%h expected v=0 r=1 d0=0000", name, o_valid, o_ready, o_data[0]);
        end
`ifdef MULTIPLE_GAIN_PIPE_SAT_FLAG_EN
        checks++;
        if (o_sat !== 4'b0000) begin
            errors++;
            $display("FAIL %s_sat: got %b expected 0000", name, o_sat);
        end
`endif
    endtask

    initial begin
        int c0;
        int a;
        int n;
        logic [31:0] u_exp [4];
        for (int l = 0; l < 4; l++) begin
            i_data[l] = '0;
            i_gain[l] = '0;
            u_data[l] = '0;
            u_gain[l] = '0;
        end
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_idle("reset_state");
        @(posedge i_clk);
        #1;

        // Q15 scale, rounding half-up (positive and negative), saturation on lane 3.
        send({16'h8000, 16'hFFFD, 16'h0003, 16'h4000},
             {16'h8000, 16'h4000, 16'h4000, 16'h4000},
             {16'h7FFF, 16'hFFFF, 16'h0002, 16'h2000}, 4'b1000, 1'b1);
        i_valid = 1'b0;
        drain();

        // Near-full-scale products that fit, and -0.5 rounding to 0.
        send({16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF},
             {16'h7FFF, 16'h4000, 16'h7FFF, 16'h8000},
             {16'h7FFE, 16'h0000, 16'h8001, 16'h8001}, 4'b0000, 1'b1);
        send({16'hFFFF, 16'h0001, 16'h0002, 16'h2000},
             {16'hFFFF, 16'hC000, 16'hC000, 16'h2000},
             {16'h0000, 16'h0000, 16'hFFFF, 16'h0800}, 4'b0000, 1'b1);
        i_valid = 1'b0;
        drain();

        // Full throughput: four back-to-back beats accepted in four cycles.
        c0 = cyc;
        for (int k = 0; k < 4; k++) send_stream(k, 1'b1);
        i_valid = 1'b0;
        checks++;
        if (cyc - c0 != 4) begin
            errors++;
            $display("FAIL throughput: got %0d cycles expected 4", cyc - c0);
        end
        drain();

        // Backpressure with irregular i_ready.
        bp_on = 1'b1;
        for (int k = 0; k < 10; k++) send_stream(k, 1'b0);
        i_valid = 1'b0;
        drain();
        bp_on = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        // Reset with beats in flight; nothing stale may emerge afterwards.
        for (int k = 0; k < 3; k++) send_stream(k + 3, 1'b0);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_idle("post_reset");
        repeat (8) @(posedge i_clk);
        #1;
        send({16'h8000, 16'hFFFD, 16'h0003, 16'h4000},
             {16'h8000, 16'h4000, 16'h4000, 16'h4000},
             {16'h7FFF, 16'hFFFF, 16'h0002, 16'h2000}, 4'b1000, 1'b1);
        i_valid = 1'b0;
        drain();

        // Unsigned, no shift, 32-bit out, two extra product registers.
        u_data[0] = 16'hFFFF; u_gain[0] = 16'hFFFF; u_exp[0] = 32'hFFFE_0001;
        u_data[1] = 16'h0002; u_gain[1] = 16'h0003; u_exp[1] = 32'h0000_0006;
        u_data[2] = 16'h0000; u_gain[2] = 16'h1234; u_exp[2] = 32'h0000_0000;
        u_data[3] = 16'h8000; u_gain[3] = 16'h0002; u_exp[3] = 32'h0001_0000;
        u_valid = 1'b1;
        @(negedge i_clk);
        checks++;
        if (u_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL u_ready: got %b expected 1", u_ready_o);
        end
        a = cyc + 1;
        @(posedge i_clk);
        #1;
        u_valid = 1'b0;
        n = 0;
        @(negedge i_clk);
        while (!u_ovalid && n < 20) begin
            n++;
            @(negedge i_clk);
        end
        checks++;
        if (!u_ovalid || cyc - a + 1 != 5) begin
            errors++;
            $display("FAIL u_latency: got v=%b lat=%0d expected v=1 lat=5", u_ovalid, cyc - a + 1);
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (u_odata[l] !== u_exp[l]) begin
                errors++;
                $display("FAIL u_data lane %0d: got %h expected %h", l, u_odata[l], u_exp[l]);
            end
        end

        repeat (3) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
